// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin share of one MC request/response port among NUM_REQ requesters, optional contention counter (MEM_ARB_STATS_EN); ports: req_* in / req_ack, rs_* out per requester, mc_rq_*/mc_rs_* to MC, outstanding/err/conf_cnt status
module mem_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_WID = 2,
  parameter int TAG_WID = 8,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [3*NUM_REQ-1:0]         req_cmd,
  input  logic [4*NUM_REQ-1:0]         req_scmd,
  input  logic [48*NUM_REQ-1:0]        req_vadr,
  input  logic [2*NUM_REQ-1:0]         req_size,
  input  logic [TAG_WID*NUM_REQ-1:0]   req_tag,
  input  logic [64*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           rs_vld,
  output logic [2:0]                   rs_cmd,
  output logic [3:0]                   rs_scmd,
  output logic [TAG_WID-1:0]           rs_tag,
  output logic [63:0]                  rs_data,
  output logic [8*NUM_REQ-1:0]         outstanding,
  output logic                         err,
  output logic [31:0]                  conf_cnt,
  output logic                         mc_rq_vld,
  output logic [2:0]                   mc_rq_cmd,
  output logic [3:0]                   mc_rq_scmd,
  output logic [47:0]                  mc_rq_vadr,
  output logic [1:0]                   mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
  output logic [63:0]                  mc_rq_data,
  output logic                         mc_rq_flush,
  input  logic                         mc_rq_stall,
  input  logic                         mc_rs_vld,
  input  logic [2:0]                   mc_rs_cmd,
  input  logic [3:0]                   mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
  input  logic [63:0]                  mc_rs_data,
  output logic                         mc_rs_stall
);
  logic [7:0] cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [ID_WID-1:0] rr_ptr, win, rs_id;
  logic [MC_RTNCTL_WIDTH-TAG_WID-1:0] rs_hi;
  logic load, found, rs_ok;
  assign mc_rq_flush = 1'b0;
  assign mc_rs_stall = 1'b0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign outstanding[8*g +: 8] = cnt[g];
    assign elig[g] = req_vld[g] && cnt[g] < 8'(MAX_OUTSTANDING);
  end
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win = ID_WID'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign load = !reset && (!mc_rq_vld || !mc_rq_stall) && |elig;
  assign req_ack = load ? NUM_REQ'(1) << win : '0;
  // the whole field above the tag is treated as the ID so stray upper bits count as out of range
  assign rs_hi = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1:TAG_WID];
  assign rs_id = rs_hi[ID_WID-1:0];
  assign rs_ok = mc_rs_vld && 64'(rs_hi) < 64'(NUM_REQ);
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_rq_vld <= 1'b0;
      mc_rq_cmd <= '0;
      mc_rq_scmd <= '0;
      mc_rq_vadr <= '0;
      mc_rq_size <= '0;
      mc_rq_rtnctl <= '0;
      mc_rq_data <= '0;
      rs_vld <= '0;
      rs_cmd <= '0;
      rs_scmd <= '0;
      rs_tag <= '0;
      rs_data <= '0;
      err <= 1'b0;
      rr_ptr <= ID_WID'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      if (load) begin
        mc_rq_vld <= 1'b1;
        mc_rq_cmd <= req_cmd[3*win +: 3];
        mc_rq_scmd <= req_scmd[4*win +: 4];
        mc_rq_vadr <= req_vadr[48*win +: 48];
        mc_rq_size <= req_size[2*win +: 2];
        mc_rq_rtnctl <= MC_RTNCTL_WIDTH'({win, req_tag[TAG_WID*win +: TAG_WID]});
        mc_rq_data <= req_data[64*win +: 64];
        rr_ptr <= win;
      end else if (!mc_rq_stall) begin
        mc_rq_vld <= 1'b0;
      end
      rs_vld <= rs_ok ? NUM_REQ'(1) << rs_id : '0;
      if (rs_ok) begin
        rs_cmd <= mc_rs_cmd;
        rs_scmd <= mc_rs_scmd;
        rs_tag <= mc_rs_rtnctl[TAG_WID-1:0];
        rs_data <= mc_rs_data;
      end
      if (mc_rs_vld && !rs_ok) err <= 1'b1;
      // counts retire on the registered response so a freed slot is grantable the cycle after rs_vld
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rs_vld[i] && !req_ack[i]) begin
          if (cnt[i] == '0) err <= 1'b1;
          else cnt[i] <= cnt[i] - 8'd1;
        end else if (req_ack[i] && !rs_vld[i]) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end
`ifdef MEM_ARB_STATS_EN
  logic [31:0] conf_q;
  logic conf_hit;
  assign conf_hit = |(elig & (elig - NUM_REQ'(1))) || (mc_rq_vld && mc_rq_stall && |elig);
  assign conf_cnt = conf_q;
  always_ff @(posedge clk) begin
    if (reset) conf_q <= '0;
    else if (conf_hit && conf_q != '1) conf_q <= conf_q + 32'd1;
  end
`else
  assign conf_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_vld;
  logic [11:0] req_cmd;
  logic [15:0] req_scmd;
  logic [191:0] req_vadr;
  logic [7:0] req_size;
  logic [31:0] req_tag;
  logic [255:0] req_data;
  logic [3:0] req_ack, rs_vld;
  logic [2:0] rs_cmd, mc_rq_cmd, mc_rs_cmd;
  logic [3:0] rs_scmd, mc_rq_scmd, mc_rs_scmd;
  logic [7:0] rs_tag;
  logic [63:0] rs_data, mc_rq_data, mc_rs_data;
  logic [31:0] outstanding, conf_cnt, mc_rq_rtnctl, mc_rs_rtnctl;
  logic err, mc_rq_vld, mc_rq_flush, mc_rq_stall, mc_rs_vld, mc_rs_stall;
  logic [47:0] mc_rq_vadr;
  logic [1:0] mc_rq_size;
  int checks = 0;
  int errors = 0;
  mem_req_arbiter dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_cmd(req_cmd), .req_scmd(req_scmd),
    .req_vadr(req_vadr), .req_size(req_size), .req_tag(req_tag), .req_data(req_data),
    .req_ack(req_ack), .rs_vld(rs_vld), .rs_cmd(rs_cmd), .rs_scmd(rs_scmd), .rs_tag(rs_tag),
    .rs_data(rs_data), .outstanding(outstanding), .err(err), .conf_cnt(conf_cnt),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr),
    .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data),
    .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld),
    .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd), .mc_rs_rtnctl(mc_rs_rtnctl),
    .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [47:0] a, input logic [7:0] t);
    req_vadr[48*i +: 48] = a;
    req_tag[8*i +: 8] = t;
    req_cmd[3*i +: 3] = 3'(i + 1);
    req_scmd[4*i +: 4] = 4'(i + 8);
    req_size[2*i +: 2] = 2'(i);
    req_data[64*i +: 64] = 64'hA000_0000_0000_0000 | 64'(i);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req_vld = '0;
    mc_rq_stall = 1'b0;
    mc_rs_vld = 1'b0;
    mc_rs_cmd = '0;
    mc_rs_scmd = '0;
    mc_rs_rtnctl = '0;
    mc_rs_data = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    req_cmd = '0; req_scmd = '0; req_vadr = '0; req_size = '0; req_tag = '0; req_data = '0;
    do_reset;
    checks++; if (mc_rq_vld !== 1'b0) begin errors++; $display("FAIL reset_mc_rq_vld got %b want 0", mc_rq_vld); end
    checks++; if (mc_rq_rtnctl !== 32'h0 || mc_rq_vadr !== 48'h0) begin errors++; $display("FAIL reset_mc_fields got %h/%h want 0", mc_rq_rtnctl, mc_rq_vadr); end
    checks++; if (req_ack !== 4'b0 || rs_vld !== 4'b0) begin errors++; $display("FAIL reset_ack_rs got %b/%b want 0", req_ack, rs_vld); end
    checks++; if (outstanding !== 32'h0 || err !== 1'b0 || conf_cnt !== 32'h0) begin errors++; $display("FAIL reset_status got %h/%b/%h want 0", outstanding, err, conf_cnt); end
    checks++; if (mc_rq_flush !== 1'b0 || mc_rs_stall !== 1'b0) begin errors++; $display("FAIL reset_consts got %b/%b want 0", mc_rq_flush, mc_rs_stall); end
  endtask
  task automatic test_single;
    set_req(2, 48'h100, 8'h5A);
    req_vld = 4'b0100;
    #1;
    checks++; if (req_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", req_ack); end
    tick;
    req_vld = '0;
    checks++; if (mc_rq_vld !== 1'b1 || mc_rq_vadr !== 48'h100 || mc_rq_rtnctl !== 32'h25A) begin errors++; $display("FAIL single_mc got %b %h %h want 1 100 25a", mc_rq_vld, mc_rq_vadr, mc_rq_rtnctl); end
    checks++; if (mc_rq_cmd !== 3'd3 || mc_rq_data !== 64'hA000_0000_0000_0002) begin errors++; $display("FAIL single_fields got %h %h want 3 a000000000000002", mc_rq_cmd, mc_rq_data); end
    checks++; if (outstanding[23:16] !== 8'd1) begin errors++; $display("FAIL single_out_inc got %0d want 1", outstanding[23:16]); end
    tick;
    checks++; if (mc_rq_vld !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", mc_rq_vld); end
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h25A; mc_rs_data = 64'hDEAD_BEEF; mc_rs_cmd = 3'd5;
    tick;
    mc_rs_vld = 1'b0;
    checks++; if (rs_vld !== 4'b0100 || rs_tag !== 8'h5A) begin errors++; $display("FAIL single_rs got %b %h want 0100 5a", rs_vld, rs_tag); end
    checks++; if (rs_data !== 64'hDEAD_BEEF || rs_cmd !== 3'd5) begin errors++; $display("FAIL single_rs_data got %h %h want deadbeef 5", rs_data, rs_cmd); end
    tick;
    checks++; if (outstanding[23:16] !== 8'd0 || rs_vld !== 4'b0) begin errors++; $display("FAIL single_out_dec got %0d %b want 0 0000", outstanding[23:16], rs_vld); end
  endtask
  task automatic test_round_robin;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] oh;
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 48'(i * 16), 8'(i + 16));
    req_vld = 4'hF;
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << order[k];
      #1;
      checks++; if (req_ack !== oh) begin errors++; $display("FAIL rr_ack_%0d got %b want %b", k, req_ack, oh); end
      tick;
    end
    req_vld = '0;
    checks++; if (outstanding !== 32'h0101_0202) begin errors++; $display("FAIL rr_outstanding got %h want 01010202", outstanding); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (conf_cnt !== 32'd6) begin errors++; $display("FAIL rr_conf got %0d want 6", conf_cnt); end
`else
    checks++; if (conf_cnt !== 32'd0) begin errors++; $display("FAIL rr_conf got %0d want 0", conf_cnt); end
`endif
  endtask
  task automatic test_back_pressure;
    do_reset;
    set_req(0, 48'h40, 8'h11);
    set_req(1, 48'h80, 8'h22);
    req_vld = 4'b0011;
    #1;
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL bp_first_ack got %b want 0001", req_ack); end
    tick;
    mc_rq_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL bp_ack_%0d got %b want 0000", k, req_ack); end
      tick;
      checks++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl !== 32'h011 || mc_rq_vadr !== 48'h40) begin errors++; $display("FAIL bp_hold_%0d got %b %h %h want 1 011 40", k, mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr); end
    end
    mc_rq_stall = 1'b0;
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL bp_resume_ack got %b want 0010", req_ack); end
    tick;
    req_vld = '0;
    checks++; if (mc_rq_rtnctl !== 32'h122 || mc_rq_vadr !== 48'h80) begin errors++; $display("FAIL bp_resume_mc got %h %h want 122 80", mc_rq_rtnctl, mc_rq_vadr); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (conf_cnt !== 32'd7) begin errors++; $display("FAIL bp_conf got %0d want 7", conf_cnt); end
`endif
  endtask
  task automatic test_outstanding_limit;
    logic [3:0] exp;
    do_reset;
    set_req(1, 48'h200, 8'h33);
    req_vld = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      exp = (k < 8) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (req_ack !== exp) begin errors++; $display("FAIL lim_ack_%0d got %b want %b", k, req_ack, exp); end
      tick;
    end
    checks++; if (outstanding[15:8] !== 8'd8 || mc_rq_vld !== 1'b0) begin errors++; $display("FAIL lim_full got %0d %b want 8 0", outstanding[15:8], mc_rq_vld); end
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h133;
    tick;
    mc_rs_vld = 1'b0;
    checks++; if (rs_vld !== 4'b0010) begin errors++; $display("FAIL lim_rs got %b want 0010", rs_vld); end
    #1;
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL lim_early_ack got %b want 0000", req_ack); end
    tick;
    checks++; if (outstanding[15:8] !== 8'd7) begin errors++; $display("FAIL lim_dec got %0d want 7", outstanding[15:8]); end
    #1;
    checks++; if (req_ack !== 4'b0010) begin errors++; $display("FAIL lim_resume_ack got %b want 0010", req_ack); end
    tick;
    req_vld = '0;
    checks++; if (outstanding[15:8] !== 8'd8) begin errors++; $display("FAIL lim_refill got %0d want 8", outstanding[15:8]); end
  endtask
  task automatic test_simultaneous;
    do_reset;
    set_req(0, 48'h300, 8'hAA);
    req_vld = 4'b0001;
    tick; tick; tick;
    req_vld = '0;
    checks++; if (outstanding[7:0] !== 8'd3) begin errors++; $display("FAIL sim_pre got %0d want 3", outstanding[7:0]); end
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h0AA;
    tick;
    mc_rs_vld = 1'b0;
    req_vld = 4'b0001;
    #1;
    checks++; if (req_ack !== 4'b0001 || rs_vld !== 4'b0001) begin errors++; $display("FAIL sim_both got %b %b want 0001 0001", req_ack, rs_vld); end
    tick;
    req_vld = '0;
    checks++; if (outstanding[7:0] !== 8'd3 || err !== 1'b0) begin errors++; $display("FAIL sim_count got %0d %b want 3 0", outstanding[7:0], err); end
  endtask
  task automatic test_errors;
    do_reset;
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h000;
    tick;
    mc_rs_vld = 1'b0;
    checks++; if (rs_vld !== 4'b0001 || err !== 1'b0) begin errors++; $display("FAIL err_route got %b %b want 0001 0", rs_vld, err); end
    tick;
    checks++; if (err !== 1'b1 || outstanding[7:0] !== 8'd0) begin errors++; $display("FAIL err_underflow got %b %0d want 1 0", err, outstanding[7:0]); end
    tick;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    do_reset;
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h400;
    tick;
    mc_rs_vld = 1'b0;
    checks++; if (err !== 1'b1 || rs_vld !== 4'b0) begin errors++; $display("FAIL err_bad_id got %b %b want 1 0000", err, rs_vld); end
    do_reset;
    for (int i = 0; i < 4; i++) set_req(i, 48'(i), 8'(i));
    req_vld = 4'hF;
    tick; tick;
    checks++; if (mc_rq_vld !== 1'b1 || outstanding !== 32'h0000_0101) begin errors++; $display("FAIL err_burst got %b %h want 1 00000101", mc_rq_vld, outstanding); end
    reset = 1'b1;
    #1;
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL err_rst_ack got %b want 0000", req_ack); end
    tick;
    checks++; if (mc_rq_vld !== 1'b0 || mc_rq_rtnctl !== 32'h0 || outstanding !== 32'h0 || conf_cnt !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL err_rst_state got %b %h %h %h %b want all 0", mc_rq_vld, mc_rq_rtnctl, outstanding, conf_cnt, err); end
    reset = 1'b0;
    #1;
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL err_rst_rr got %b want 0001", req_ack); end
    tick;
    req_vld = '0;
    mc_rs_vld = 1'b1; mc_rs_rtnctl = 32'h202;
    tick;
    mc_rs_vld = 1'b0;
    tick;
    checks++; if (err !== 1'b1 || outstanding !== 32'h0000_0001) begin errors++; $display("FAIL err_late_rs got %b %h want 1 00000001", err, outstanding); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_back_pressure;
    test_outstanding_limit;
    test_simultaneous;
    test_errors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
